// File: rtl/phase_frame_loader.sv
// phase_frame_loader: pulls command frames from the proto245 RX FIFO, stages
// PHASE / ENABLE payloads, and commits the staging bank to the active outputs
// atomically on the next PWM period start.
module phase_frame_loader #(
  parameter int                NUM_CHANNELS = 128,
  parameter int                DATA_W       = 8,
  parameter int                PHASE_W      = 8,
  parameter int                PHASE_MAX    = 99,
  parameter int                TIMEOUT_CYC  = 1_000_000,
  parameter logic [DATA_W-1:0] CMD_PHASE    = 'h01,
  parameter logic [DATA_W-1:0] CMD_ENABLE   = 'h02,
  parameter logic [DATA_W-1:0] CMD_CLR      = 'h03
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    period_start,
  input  logic [DATA_W-1:0]       rxfifo_data,
  input  logic                    rxfifo_valid,
  input  logic                    rxfifo_empty,
  output logic                    rxfifo_rd,
  output logic [PHASE_W-1:0]      phase [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] pwm_en,
  output logic                    commit_pend,
  output logic [15:0]             frame_cnt,
  output logic                    cmd_err,
  output logic                    range_err,
  output logic                    timeout_err,
  output logic [1:0]              fsm_state
);

  localparam int MASK_BYTES = (NUM_CHANNELS + 7) / 8;
  localparam int IDX_W      = $clog2(NUM_CHANNELS + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PHASE_W-1:0] PH_MAX  = PHASE_W'(PHASE_MAX);
  localparam logic [IDX_W-1:0]   LAST_PH = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0]   LAST_MB = IDX_W'(MASK_BYTES - 1);
  localparam logic [TO_W-1:0]    TO_LIM  = TO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_CMD, S_PHASE, S_MASK, S_PEND} state_t;

  state_t                    state, state_n;
  logic                      rd_busy;
  logic [IDX_W-1:0]          idx;
  logic [TO_W-1:0]           to_cnt;
  logic                      tmo;
  logic [PHASE_W-1:0]        stage_ph [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   stage_en;
  logic [PHASE_W-1:0]        ph_raw, ph_val;
  logic                      ph_clamp;

  // FIFO handshake: rxfifo_rd is a 1-cycle strobe raised only when the FIFO
  // is not empty, no read is outstanding and no commit is pending; the byte
  // returns one cycle later and is consumed on the cycle rxfifo_valid is 1.
  assign rxfifo_rd   = !rst && !rxfifo_empty && !rd_busy && (state != S_PEND);
  assign commit_pend = (state == S_PEND);
  assign fsm_state   = state;

  assign ph_raw   = rxfifo_data[PHASE_W-1:0];
  assign ph_clamp = (ph_raw > PH_MAX);
  assign ph_val   = ph_clamp ? PH_MAX : ph_raw;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_n;
  end

  // Next-state decode, including the mid-frame idle timeout.
  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    case (state)
      S_CMD: begin
        if (rxfifo_valid) begin
          if (rxfifo_data == CMD_PHASE)       state_n = S_PHASE;
          else if (rxfifo_data == CMD_ENABLE) state_n = S_MASK;
        end
      end
      S_PHASE: begin
        if (rxfifo_valid) begin
          if (idx == LAST_PH) state_n = S_PEND;
        end else if (to_cnt == TO_LIM) begin
          tmo     = 1'b1;
          state_n = S_CMD;
        end
      end
      S_MASK: begin
        if (rxfifo_valid) begin
          if (idx == LAST_MB) state_n = S_PEND;
        end else if (to_cnt == TO_LIM) begin
          tmo     = 1'b1;
          state_n = S_CMD;
        end
      end
      S_PEND: begin
        if (period_start) state_n = S_CMD;
      end
      default: state_n = S_CMD;
    endcase
  end

  // Datapath: read tracking, timeout counter, staging writes, flags, commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy     <= 1'b0;
      idx         <= '0;
      to_cnt      <= '0;
      stage_en    <= '0;
      pwm_en      <= '0;
      frame_cnt   <= '0;
      cmd_err     <= 1'b0;
      range_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        stage_ph[ch] <= '0;
        phase[ch]    <= '0;
      end
    end else begin
      if (rxfifo_rd)         rd_busy <= 1'b1;
      else if (rxfifo_valid) rd_busy <= 1'b0;

      if ((state == S_PHASE || state == S_MASK) && !rxfifo_valid && !tmo)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      case (state)
        S_CMD: begin
          if (rxfifo_valid) begin
            idx <= '0;
            if (rxfifo_data == CMD_CLR) begin
              cmd_err     <= 1'b0;
              range_err   <= 1'b0;
              timeout_err <= 1'b0;
            end else if (rxfifo_data != CMD_PHASE && rxfifo_data != CMD_ENABLE) begin
              cmd_err <= 1'b1;
            end
          end
        end
        S_PHASE, S_MASK: begin
          if (rxfifo_valid) begin
            idx <= idx + 1'b1;
            if (state == S_PHASE) begin
              if (ph_clamp) range_err <= 1'b1;
              for (int ch = 0; ch < NUM_CHANNELS; ch++)
                if (idx == IDX_W'(ch)) stage_ph[ch] <= ph_val;
            end else begin
              for (int ch = 0; ch < NUM_CHANNELS; ch++)
                if (idx == IDX_W'(ch / 8)) stage_en[ch] <= rxfifo_data[ch % 8];
            end
          end else if (tmo) begin
            // Abort: staging falls back to what is currently driven.
            timeout_err <= 1'b1;
            stage_en    <= pwm_en;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) stage_ph[ch] <= phase[ch];
          end
        end
        S_PEND: begin
          if (period_start) begin
            frame_cnt <= frame_cnt + 16'd1;
            pwm_en    <= stage_en;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) phase[ch] <= stage_ph[ch];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_frame_loader.sv
// tb_phase_frame_loader: randomized frames against a frame-level reference
// model of the staging/active banks and sticky flags.
module tb_phase_frame_loader;

  localparam int NCH  = 128;
  localparam int PMAX = 99;
  localparam int TO   = 300;
  localparam int MB   = (NCH + 7) / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            period_start = 1'b0;
  logic [7:0]      rxfifo_data = '0;
  logic            rxfifo_valid = 1'b0;
  logic            rxfifo_empty = 1'b1;
  logic            rxfifo_rd;
  logic [7:0]      phase [NCH];
  logic [NCH-1:0]  pwm_en;
  logic            commit_pend;
  logic [15:0]     frame_cnt;
  logic            cmd_err, range_err, timeout_err;
  logic [1:0]      fsm_state;

  phase_frame_loader #(
    .NUM_CHANNELS(NCH), .DATA_W(8), .PHASE_W(8), .PHASE_MAX(PMAX), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .period_start(period_start),
    .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid), .rxfifo_empty(rxfifo_empty),
    .rxfifo_rd(rxfifo_rd), .phase(phase), .pwm_en(pwm_en), .commit_pend(commit_pend),
    .frame_cnt(frame_cnt), .cmd_err(cmd_err), .range_err(range_err),
    .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // FIFO model: byte queue, read latency 1
  logic [7:0] fifo_q[$];
  logic       rd_seen;
  initial begin
    forever begin
      @(negedge clk);
      rd_seen = rxfifo_rd;
      @(posedge clk);
      #1;
      rxfifo_valid = 1'b0;
      if (rd_seen && fifo_q.size() > 0) begin
        rxfifo_data  = fifo_q.pop_front();
        rxfifo_valid = 1'b1;
      end
      rxfifo_empty = (fifo_q.size() == 0);
    end
  end

  // Reference model (frame level)
  logic [7:0]     m_stage_ph [NCH];
  logic [7:0]     m_act_ph   [NCH];
  logic [NCH-1:0] m_stage_en, m_act_en;
  logic [15:0]    m_cnt;
  logic           m_cmd_err, m_range_err, m_to_err;
  logic [7:0]     pl [NCH];
  logic [7:0]     mb [MB];

  // Scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_stage_ph[i] = '0;
      m_act_ph[i]   = '0;
    end
    m_stage_en = '0; m_act_en = '0; m_cnt = '0;
    m_cmd_err = 1'b0; m_range_err = 1'b0; m_to_err = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic model_phase(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      m_stage_ph[i] = (int'(pl[i]) > PMAX) ? 8'(PMAX) : pl[i];
      if (int'(pl[i]) > PMAX) m_range_err = 1'b1;
    end
  endtask

  task automatic model_enable();
    for (int ch = 0; ch < NCH; ch++) m_stage_en[ch] = mb[ch / 8][ch % 8];
  endtask

  task automatic push_phase_frame();
    push(8'h01);
    for (int i = 0; i < NCH; i++) push(pl[i]);
  endtask

  task automatic push_enable_frame();
    push(8'h02);
    for (int k = 0; k < MB; k++) push(mb[k]);
  endtask

  task automatic check_all(input string tag, input logic exp_pend);
    for (int i = 0; i < NCH; i++) exp_q.push_back(m_act_ph[i]);
    for (int i = 0; i < NCH; i++) check_eq($sformatf("%s ph[%0d]", tag, i), 32'(phase[i]), 32'(exp_q.pop_front()));
    for (int k = 0; k < NCH / 32; k++)
      check_eq($sformatf("%s en[%0d]", tag, k), pwm_en[32*k +: 32], m_act_en[32*k +: 32]);
    check_eq({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    check_eq({tag, " commit_pend"}, 32'(commit_pend), 32'(exp_pend));
    check_eq({tag, " cmd_err"}, 32'(cmd_err), 32'(m_cmd_err));
    check_eq({tag, " range_err"}, 32'(range_err), 32'(m_range_err));
    check_eq({tag, " timeout_err"}, 32'(timeout_err), 32'(m_to_err));
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    while (!commit_pend && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " pend"}, 32'(commit_pend), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || rxfifo_valid || rxfifo_rd) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " drained"}, 32'(fifo_q.size()), 32'd0);
    tick(4);
  endtask

  task automatic pulse_ps();
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  task automatic commit(input string tag);
    pulse_ps();
    for (int i = 0; i < NCH; i++) m_act_ph[i] = m_stage_ph[i];
    m_act_en = m_stage_en;
    m_cnt    = m_cnt + 16'd1;
    check_all(tag, 1'b0);
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Main sequence
  initial begin
    int rds, n;
    model_reset();
    rst = 1'b1;
    tick(3);
    check_all("reset", 1'b0);
    check_eq("reset rd", 32'(rxfifo_rd), 32'd0);
    rst = 1'b0;
    tick(2);

    // Ramp phases 0..127
    for (int i = 0; i < NCH; i++) pl[i] = 8'(i);
    push_phase_frame(); model_phase(NCH);
    wait_pend("t1");
    check_all("t1 staged", 1'b1);
    commit("t1");

    // period_start outside a pending commit does nothing
    pulse_ps();
    tick(2);
    check_eq("idle ps frame_cnt", 32'(frame_cnt), 32'(m_cnt));

    // Enable mask 0xA5
    for (int k = 0; k < MB; k++) mb[k] = 8'hA5;
    push_enable_frame(); model_enable();
    wait_pend("t2");
    check_all("t2 staged", 1'b1);
    commit("t2");
    check_eq("t2 en0", 32'(pwm_en[0]), 32'd1);
    check_eq("t2 en1", 32'(pwm_en[1]), 32'd0);
    check_eq("t2 en2", 32'(pwm_en[2]), 32'd1);

    // Clamp at channel 5, then clear flags
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, PMAX));
    pl[5] = 8'hC8;
    push_phase_frame(); model_phase(NCH);
    wait_pend("t3");
    commit("t3");
    check_eq("t3 ph5", 32'(phase[5]), 32'd99);
    check_eq("t3 range_err", 32'(range_err), 32'd1);
    push(8'h03);
    m_cmd_err = 1'b0; m_range_err = 1'b0; m_to_err = 1'b0;
    wait_drain("t3 clr");
    check_all("t3 clr", 1'b0);

    // Timeout after 60 payload bytes
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
    push(8'h01);
    for (int i = 0; i < 60; i++) push(pl[i]);
    model_phase(60);
    wait_drain("t4");
    tick(TO / 2);
    check_eq("t4 early timeout", 32'(timeout_err), 32'd0);
    tick(TO);
    m_to_err = 1'b1;
    for (int i = 0; i < NCH; i++) m_stage_ph[i] = m_act_ph[i];
    m_stage_en = m_act_en;
    check_all("t4 aborted", 1'b0);
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
    push_phase_frame(); model_phase(NCH);
    wait_pend("t4 next");
    commit("t4 next");

    // Bad opcode, then final byte coincident with period_start
    push(8'h7E); m_cmd_err = 1'b1;
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
    push_phase_frame(); model_phase(NCH);
    n = 0;
    while (!(rxfifo_valid && fifo_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5 last byte seen", 32'(rxfifo_valid), 32'd1);
    pulse_ps();
    check_all("t5 no commit", 1'b1);
    commit("t5");

    // Second frame queued while pending
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < MB; k++) mb[k] = 8'($urandom_range(0, 255));
    push_phase_frame(); model_phase(NCH);
    push_enable_frame();
    wait_pend("t6a");
    rds = 0;
    repeat (30) begin
      @(negedge clk);
      if (rxfifo_rd) rds++;
    end
    check_eq("t6 reads while pend", 32'(rds), 32'd0);
    check_eq("t6 queue held", 32'(fifo_q.size()), 32'(MB + 1));
    commit("t6a");
    model_enable();
    wait_pend("t6b");
    commit("t6b");

    // Random mix of frames and bad opcodes
    repeat (4) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
          push_phase_frame(); model_phase(NCH);
        end
        1: begin
          for (int k = 0; k < MB; k++) mb[k] = 8'($urandom_range(0, 255));
          push_enable_frame(); model_enable();
        end
        default: begin
          push(8'($urandom_range(4, 255))); m_cmd_err = 1'b1;
          for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 120));
          push_phase_frame(); model_phase(NCH);
        end
      endcase
      wait_pend("rnd");
      commit("rnd");
    end

    // Reset mid-frame discards everything
    push(8'h01);
    for (int i = 0; i < 30; i++) push(8'($urandom_range(0, 255)));
    tick(20);
    rst = 1'b1;
    fifo_q.delete();
    tick(3);
    model_reset();
    check_all("rst mid", 1'b0);
    rst = 1'b0;
    tick(3);
    for (int i = 0; i < NCH; i++) pl[i] = 8'($urandom_range(0, 255));
    push_phase_frame(); model_phase(NCH);
    wait_pend("post rst");
    commit("post rst");

    finish_run();
  end

  // Global time bound
  initial begin
    #500_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected done");
    finish_run();
  end

endmodule
